// File: rtl/param_alu_pkg.sv
// Shared definitions for param_alu: op encodings, FSM states, legal parameter ranges.
package param_alu_pkg;

  localparam int unsigned WIDTH_MIN    = 4;
  localparam int unsigned WIDTH_MAX    = 32;
  localparam int unsigned MULT_LAT_MIN = 2;
  localparam int unsigned MULT_LAT_MAX = 8;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_DIV = 3'b101,
    OP_SUB = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_e;

endpackage

// File: rtl/param_alu_mult.sv
// Pipelined unsigned multiplier with an in-band valid bit.
// Holds the first MULT_LAT-1 stages; the parent's result register is the
// final stage, so a product reaches the ALU outputs MULT_LAT cycles after
// in_valid is sampled.
module param_alu_mult
  import param_alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_prod
);

  localparam int unsigned STAGES = MULT_LAT - 1;

  logic [STAGES-1:0]  vld_q;
  logic [2*WIDTH-1:0] prod_q [STAGES];
  logic [2*WIDTH-1:0] prod_in;

  assign prod_in = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Shift product and valid bit down the pipeline; reset drops in-flight work
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) prod_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_valid;
      prod_q[0] <= prod_in;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_prod  = prod_q[STAGES-1];

endmodule

// File: rtl/param_alu.sv
// Parameterised ALU: single-cycle ADD/AND/XOR/SUB, pipelined MUL and an
// optional iterative restoring divider enabled by macro PARAM_ALU_DIV_EN.
// Without the macro, op 101 behaves as the illegal op.
module param_alu
  import param_alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 err
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      MULT_LAT < MULT_LAT_MIN || MULT_LAT > MULT_LAT_MAX) begin : g_cfg_check
    $error("param_alu: WIDTH or MULT_LAT outside legal range");
  end

  op_e    op_in;
  state_e state_q, state_d;
  logic   accept;
  logic   mul_start;
  logic   mul_vld;
  logic [2*WIDTH-1:0] mul_prod;

  assign op_in     = op_e'(op);
  assign accept    = start && (state_q == IDLE);
  assign mul_start = accept && (op_in == OP_MUL);
  assign busy      = (state_q != IDLE);

  param_alu_mult #(
    .WIDTH    (WIDTH),
    .MULT_LAT (MULT_LAT)
  ) u_mult (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mul_start),
    .a         (A),
    .b         (B),
    .out_valid (mul_vld),
    .out_prod  (mul_prod)
  );

  // Single-cycle op results and whether the op completes at latency 1
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] fast_res;
  logic               fast_carry, fast_err, fast_op;

  always_comb begin
    sum        = {1'b0, A} + {1'b0, B};
    diff       = {1'b0, A} - {1'b0, B};
    fast_res   = '0;
    fast_carry = 1'b0;
    fast_err   = 1'b0;
    fast_op    = 1'b0;
    case (op_in)
      OP_ADD: begin
        fast_op             = 1'b1;
        fast_res[WIDTH-1:0] = sum[WIDTH-1:0];
        fast_carry          = sum[WIDTH];
      end
      OP_AND: begin
        fast_op             = 1'b1;
        fast_res[WIDTH-1:0] = A & B;
      end
      OP_XOR: begin
        fast_op             = 1'b1;
        fast_res[WIDTH-1:0] = A ^ B;
      end
      OP_SUB: begin
        fast_op             = 1'b1;
        fast_res[WIDTH-1:0] = diff[WIDTH-1:0];
        fast_carry          = diff[WIDTH];
      end
`ifndef PARAM_ALU_DIV_EN
      OP_DIV: begin
        fast_op  = 1'b1;
        fast_err = 1'b1;
      end
`endif
      OP_ILL: begin
        fast_op  = 1'b1;
        fast_err = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PARAM_ALU_DIV_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] div_rem_q, div_quo_q, div_dvs_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [WIDTH:0]   div_sh, div_try;
  logic [WIDTH-1:0] div_rem_d, div_quo_d;
  logic             div_last;

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    div_sh  = {div_rem_q, div_quo_q[WIDTH-1]};
    div_try = div_sh - {1'b0, div_dvs_q};
    if (!div_try[WIDTH]) begin
      div_rem_d = div_try[WIDTH-1:0];
      div_quo_d = {div_quo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_d = div_sh[WIDTH-1:0];
      div_quo_d = {div_quo_q[WIDTH-2:0], 1'b0};
    end
    div_last = (state_q == DIV_RUN) && (div_cnt_q == CNT_W'(WIDTH - 1));
  end

  // Divider working registers: load on accept, iterate while running
  always_ff @(posedge clk) begin
    if (reset) begin
      div_rem_q <= '0;
      div_quo_q <= '0;
      div_dvs_q <= '0;
      div_cnt_q <= '0;
    end else if (accept && (op_in == OP_DIV)) begin
      div_rem_q <= '0;
      div_quo_q <= A;
      div_dvs_q <= B;
      div_cnt_q <= '0;
    end else if (state_q == DIV_RUN) begin
      div_rem_q <= div_rem_d;
      div_quo_q <= div_quo_d;
      div_cnt_q <= div_cnt_q + CNT_W'(1);
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: leave a run state on the same edge that raises done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mul_start) state_d = MUL_RUN;
`ifdef PARAM_ALU_DIV_EN
        else if (accept && (op_in == OP_DIV)) state_d = DIV_RUN;
`endif
      end
      MUL_RUN: if (mul_vld) state_d = IDLE;
`ifdef PARAM_ALU_DIV_EN
      DIV_RUN: if (div_last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output registers: hold until the next completion of any kind
  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && fast_op) begin
        done   <= 1'b1;
        result <= fast_res;
        carry  <= fast_carry;
        err    <= fast_err;
      end
      if ((state_q == MUL_RUN) && mul_vld) begin
        done   <= 1'b1;
        result <= mul_prod;
        carry  <= 1'b0;
        err    <= 1'b0;
      end
`ifdef PARAM_ALU_DIV_EN
      if (div_last) begin
        done   <= 1'b1;
        result <= {div_rem_d, div_quo_d};
        carry  <= 1'b0;
        err    <= (div_dvs_q == '0);
      end
`endif
    end
  end

endmodule

// File: tb/tb_param_alu.sv
// Directed self-checking bench for param_alu (WIDTH=8, MULT_LAT=3).
// Covers divider vectors when PARAM_ALU_DIV_EN is defined, otherwise op 101 as illegal.
module tb_param_alu;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [2:0]     op;
  logic [W-1:0]   A, B;
  logic           busy, done, carry, err;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  param_alu #(
    .WIDTH    (W),
    .MULT_LAT (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and sample away from it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = s;
    op    = o;
    A     = a;
    B     = b;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drive(1'b0, 3'b000, '0, '0);
    repeat (2) tick;
    chk("rst_busy",   busy,   0);
    chk("rst_done",   done,   0);
    chk("rst_result", result, 0);
    chk("rst_carry",  carry,  0);
    chk("rst_err",    err,    0);
    reset = 1'b0;
    tick;

    // ADD with carry out
    drive(1'b1, 3'b001, 8'hFF, 8'h01);
    tick;
    start = 1'b0;
    chk("add_done",   done,   1);
    chk("add_result", result, 16'h0000);
    chk("add_carry",  carry,  1);
    chk("add_err",    err,    0);
    chk("add_busy",   busy,   0);
    tick;
    chk("add_done_pulse", done,   0);
    chk("add_hold_res",   result, 16'h0000);
    chk("add_hold_carry", carry,  1);

    // SUB with borrow, then XOR back-to-back
    drive(1'b1, 3'b110, 8'd3, 8'd5);
    tick;
    chk("sub_done",   done,   1);
    chk("sub_result", result, 16'h00FE);
    chk("sub_carry",  carry,  1);
    drive(1'b1, 3'b011, 8'hF0, 8'h3C);
    tick;
    start = 1'b0;
    chk("xor_done",   done,   1);
    chk("xor_result", result, 16'h00CC);
    chk("xor_carry",  carry,  0);

    // MUL with an XOR start held during busy; it is accepted in the done cycle
    drive(1'b1, 3'b100, 8'hFF, 8'hFF);
    tick;
    drive(1'b1, 3'b011, 8'h01, 8'h02);
    chk("mul_c1_busy", busy,   1);
    chk("mul_c1_done", done,   0);
    tick;
    chk("mul_c2_busy", busy,   1);
    chk("mul_c2_done", done,   0);
    chk("mul_c2_res",  result, 16'h00CC);
    tick;
    chk("mul_done",    done,   1);
    chk("mul_busy",    busy,   0);
    chk("mul_result",  result, 16'hFE01);
    chk("mul_carry",   carry,  0);
    chk("mul_err",     err,    0);
    tick;
    start = 1'b0;
    chk("post_mul_xor_done", done,   1);
    chk("post_mul_xor_res",  result, 16'h0003);
    tick;
    chk("post_mul_idle_done", done, 0);

    // Illegal op
    drive(1'b1, 3'b111, 8'h12, 8'h34);
    tick;
    start = 1'b0;
    chk("ill_done",   done,   1);
    chk("ill_err",    err,    1);
    chk("ill_result", result, 0);
    chk("ill_carry",  carry,  0);

    // Known outputs, then NOP held for 5 cycles
    drive(1'b1, 3'b001, 8'h12, 8'h34);
    tick;
    chk("add2_result", result, 16'h0046);
    chk("add2_err",    err,    0);
    drive(1'b1, 3'b000, 8'hAA, 8'h55);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("nop_done", done, 0);
      chk("nop_busy", busy, 0);
    end
    start = 1'b0;
    chk("nop_result", result, 16'h0046);
    chk("nop_carry",  carry,  0);
    chk("nop_err",    err,    0);

    // Reset in the second cycle of a MUL, with a coincident start
    drive(1'b1, 3'b100, 8'h10, 8'h10);
    tick;
    start = 1'b0;
    chk("mulrst_c1_busy", busy, 1);
    tick;
    chk("mulrst_c2_busy", busy, 1);
    reset = 1'b1;
    drive(1'b1, 3'b001, 8'h01, 8'h01);
    tick;
    chk("mulrst_busy",   busy,   0);
    chk("mulrst_done",   done,   0);
    chk("mulrst_result", result, 0);
    chk("mulrst_carry",  carry,  0);
    chk("mulrst_err",    err,    0);
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mulrst_no_done", done, 0);
    end
    chk("mulrst_res_after", result, 0);

`ifdef PARAM_ALU_DIV_EN
    // DIV 100/7
    drive(1'b1, 3'b101, 8'd100, 8'd7);
    tick;
    start = 1'b0;
    chk("div_c1_busy", busy, 1);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("div_latency", n,      9);
    chk("div_busy",    busy,   0);
    chk("div_result",  result, 16'h020E);
    chk("div_err",     err,    0);
    tick;

    // DIV by zero
    drive(1'b1, 3'b101, 8'h5A, 8'h00);
    tick;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("div0_latency", n,      9);
    chk("div0_result",  result, 16'h5AFF);
    chk("div0_err",     err,    1);
    chk("div0_carry",   carry,  0);
`else
    // Op 101 without the divider is illegal
    drive(1'b1, 3'b101, 8'd100, 8'd7);
    tick;
    start = 1'b0;
    chk("div_ill_done",   done,   1);
    chk("div_ill_err",    err,    1);
    chk("div_ill_result", result, 0);
    chk("div_ill_busy",   busy,   0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 The module SHALL have parameter MULT_LAT, default 3, multiply latency in cycles (legal range 2..8).
REQ-003 The module SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The module SHALL have port start  input  1  request strobe, sampled on each clk edge.
REQ-006 The module SHALL have port op  input  3  operation code.
REQ-007 The module SHALL have ports A and B  input  WIDTH  operands.
REQ-008 The module SHALL have port busy  output  1  multi-cycle operation in flight.
REQ-009 The module SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 The module SHALL have port result  output  2*WIDTH  operation result.
REQ-011 The module SHALL have port carry  output  1  carry (ADD) or borrow (SUB) flag.
REQ-012 The module SHALL have port err  output  1  error flag, valid with done.

Function
REQ-013 The module SHALL decode op as: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 DIV, 110 SUB, 111 illegal.
REQ-014 The module SHALL accept start only when busy=0; start while busy=1 is ignored with no side effect.
REQ-015 The module SHALL ignore start with op=NOP: no done pulse, and outputs unchanged.
REQ-016 The module SHALL complete ADD, AND, XOR, SUB and illegal ops with done on the edge following acceptance (latency 1), with busy never asserted, so back-to-back starts yield one done per cycle.
REQ-017 The module SHALL compute ADD as the zero-extended sum, with carry = bit WIDTH of the sum; AND and XOR zero-extended; SUB low WIDTH bits = A-B mod 2^WIDTH, upper bits 0, carry = (A<B).
REQ-018 The module SHALL compute MUL as the full 2*WIDTH unsigned product, with done exactly MULT_LAT cycles after the acceptance edge.
REQ-019 The module SHALL implement the FSM states IDLE, MUL_RUN and DIV_RUN: IDLE->MUL_RUN on accepted MUL; IDLE->DIV_RUN on accepted DIV (macro on); RUN->IDLE on the edge that asserts done.
REQ-020 The module SHALL drive busy=1 exactly when the state is not IDLE; busy SHALL be 0 in the done cycle, so a start in that cycle is accepted.
REQ-021 The module SHALL hold result, carry and err stable from a done pulse until the next done or reset.
REQ-022 The module SHALL clear carry on every op other than ADD and SUB; err=1 only on illegal op or divide-by-zero.
REQ-023 The module SHALL treat the illegal op as: result=0, carry=0, err=1, done at latency 1.

Reset
REQ-024 The module SHALL, while reset=1, force state IDLE, busy=0, done=0, result=0, carry=0, err=0, and clear all pipeline and counter registers.
REQ-025 The module SHALL abort an in-flight operation on reset, with no done for it afterwards; a start coincident with reset is ignored.

Configuration
REQ-026 The module SHALL, with macro PARAM_ALU_DIV_EN defined, implement DIV as an iterative restoring divider: result = {remainder, quotient}, each WIDTH bits, with done WIDTH+1 cycles after acceptance.
REQ-027 The module SHALL, for DIV with B=0 (macro defined), return quotient all ones, remainder = A, err=1, with unchanged latency.
REQ-028 The module SHALL, without PARAM_ALU_DIV_EN, treat op 101 as the illegal op (REQ-023), instantiate no divider logic and never enter DIV_RUN.

Structure
REQ-029 The module SHALL take the op enum (op_e), the state enum and the legal-range constants from the shared package param_alu_pkg.
REQ-030 The module SHALL implement the multiplier in sub-module param_alu_mult, a MULT_LAT-stage pipeline with an in-band valid bit, parameterised by WIDTH and MULT_LAT.

Verification
REQ-031 The bench SHALL check: ADD A=8'hFF B=8'h01 -> next cycle done=1, result=16'h0000, carry=1.
REQ-032 The bench SHALL check: MUL A=8'hFF B=8'hFF, MULT_LAT=3 -> done exactly 3 cycles after acceptance, result=16'hFE01, busy=1 for 2 cycles; a start with op XOR during busy is ignored.
REQ-033 The bench SHALL check: SUB A=3 B=5 -> result=16'h00FE, carry=1; then XOR A=8'hF0 B=8'h3C on the next cycle -> result=16'h00CC, carry=0.
REQ-034 The bench SHALL check: with the macro on, DIV A=100 B=7 -> done after 9 cycles, result={8'd2, 8'd14}; DIV B=0 -> result={A, 8'hFF}, err=1.
REQ-035 The bench SHALL check: reset asserted in the second cycle of a MUL -> all outputs 0 the next cycle and no done afterwards; op 111 -> done with err=1, result=0.
REQ-036 The bench SHALL check: start held with op=NOP for 5 cycles -> no done and outputs unchanged.
